// File: rtl/vga_sync_decoder_if.sv
// Video tap bus: sync/colour samples from the connector side and the decoded
// pixel stream, lock status and counters produced by the decoder.
interface vga_sync_decoder_if;
   logic       hsync_in;
   logic       vsync_in;
   logic [2:0] rgb_in;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic [2:0] pix_rgb;
   logic       pix_valid;
   logic       frame_start;
   logic       locked;
   logic [7:0] frame_count;
   logic [7:0] err_count;

   modport master (
      output hsync_in, vsync_in, rgb_in,
      input  pix_x, pix_y, pix_rgb, pix_valid, frame_start,
      input  locked, frame_count, err_count
   );

   modport slave (
      input  hsync_in, vsync_in, rgb_in,
      output pix_x, pix_y, pix_rgb, pix_valid, frame_start,
      output locked, frame_count, err_count
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// Loopback monitor for the VGA output: rebuilds pixel coordinates from the
// sync stream, tracks timing lock and counts completed frames and lock losses.
module vga_sync_decoder #(
   parameter int H_TOTAL         = 800,
   parameter int V_TOTAL         = 525,
   parameter int H_VISIBLE       = 640,
   parameter int V_VISIBLE       = 480,
   parameter int H_OFFSET        = 144,
   parameter int V_OFFSET        = 35,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input logic               clk25,
   input logic               reset,
   vga_sync_decoder_if.slave vid
);

   localparam logic        ACT_LOW   = (SYNC_ACTIVE_LOW != 0);
   localparam logic [9:0]  MAX_POS   = 10'd1023;
   localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
   localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
   localparam logic [10:0] H_LO      = 11'(H_OFFSET);
   localparam logic [10:0] H_HI      = 11'(H_OFFSET + H_VISIBLE);
   localparam logic [10:0] V_LO      = 11'(V_OFFSET);
   localparam logic [10:0] V_HI      = 11'(V_OFFSET + V_VISIBLE);
   localparam logic [9:0]  X_OFF     = 10'(H_OFFSET);
   localparam logic [9:0]  Y_OFF     = 10'(V_OFFSET);

   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

   // Sync samples are stored normalised: 1 always means asserted.
   logic       hs_q, hs_q2, vs_q, vs_q2;
   logic [2:0] rgb_q;
   logic [9:0] h_pos, v_cnt;
   state_t     state;
   logic       skip_line;

   logic [9:0] pix_x_reg, pix_y_reg;
   logic [2:0] pix_rgb_reg;
   logic       pix_valid_reg, frame_start_reg, locked_reg;
   logic [7:0] frame_count_reg, err_count_reg;

   logic       hs_edge, vs_edge;
   logic [9:0] h_pos_next, v_cnt_next, v_cnt_inc;
   logic       line_ok, frame_ok, h_sat, v_sat;
   logic       track_fail, lock_fail, locked_next;
   logic       visible;
   logic [9:0] x_next, y_next;

   assign hs_edge    = hs_q & ~hs_q2;
   assign vs_edge    = vs_q & ~vs_q2;
   assign h_pos_next = hs_edge ? 10'd0 : ((h_pos == MAX_POS) ? MAX_POS : h_pos + 10'd1);
   assign v_cnt_inc  = (v_cnt == MAX_POS) ? MAX_POS : v_cnt + 10'd1;
   // A coincident hsync edge already belongs to the new frame, hence the load of 1.
   assign v_cnt_next = vs_edge ? {9'd0, hs_edge} : (hs_edge ? v_cnt_inc : v_cnt);

   assign line_ok  = (({1'b0, h_pos} + 11'd1) == H_TOTAL_W);
   assign frame_ok = ({1'b0, v_cnt} == V_TOTAL_W);
   assign h_sat    = (h_pos_next == MAX_POS);
   assign v_sat    = (v_cnt_next == MAX_POS);

   assign track_fail  = (hs_edge && !skip_line && !line_ok) || h_sat;
   assign lock_fail   = (hs_edge && !line_ok) || (vs_edge && !frame_ok) || h_sat || v_sat;
   assign locked_next = ((state == TRACK) && !track_fail && vs_edge && frame_ok) ||
                        ((state == LOCKED) && !lock_fail);

   // Decode uses the counter values being loaded this edge so the coordinates
   // line up with rgb_q, the sample they describe.
   assign visible = ({1'b0, h_pos_next} >= H_LO) && ({1'b0, h_pos_next} < H_HI) &&
                    ({1'b0, v_cnt_next} >= V_LO) && ({1'b0, v_cnt_next} < V_HI);
   assign x_next  = h_pos_next - X_OFF;
   assign y_next  = v_cnt_next - Y_OFF;

   always_ff @(posedge clk25 or posedge reset) begin
      if (reset) begin
         hs_q            <= 1'b0;
         hs_q2           <= 1'b0;
         vs_q            <= 1'b0;
         vs_q2           <= 1'b0;
         rgb_q           <= 3'd0;
         h_pos           <= 10'd0;
         v_cnt           <= 10'd0;
         pix_x_reg       <= 10'd0;
         pix_y_reg       <= 10'd0;
         pix_rgb_reg     <= 3'd0;
         pix_valid_reg   <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         hs_q            <= vid.hsync_in ^ ACT_LOW;
         vs_q            <= vid.vsync_in ^ ACT_LOW;
         rgb_q           <= vid.rgb_in;
         hs_q2           <= hs_q;
         vs_q2           <= vs_q;
         h_pos           <= h_pos_next;
         v_cnt           <= v_cnt_next;
         pix_valid_reg   <= visible && locked_next;
         frame_start_reg <= visible && locked_next && (x_next == 10'd0) && (y_next == 10'd0);
         if (visible) begin
            pix_x_reg   <= x_next;
            pix_y_reg   <= y_next;
            pix_rgb_reg <= rgb_q;
         end
      end
   end

   always_ff @(posedge clk25 or posedge reset) begin
      if (reset) begin
         state           <= SEARCH;
         skip_line       <= 1'b0;
         locked_reg      <= 1'b0;
         frame_count_reg <= 8'd0;
         err_count_reg   <= 8'd0;
      end else begin
         locked_reg <= locked_next;
         case (state)
            SEARCH: begin
               if (vs_edge) begin
                  state     <= TRACK;
                  skip_line <= 1'b1;
               end
            end
            TRACK: begin
               // The first line after entry started before we were watching.
               if (track_fail) begin
                  state <= SEARCH;
               end else begin
                  if (hs_edge) skip_line <= 1'b0;
                  if (vs_edge && frame_ok) state <= LOCKED;
               end
            end
            LOCKED: begin
               if (lock_fail) begin
                  state <= SEARCH;
                  if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
               end else if (vs_edge) begin
                  frame_count_reg <= frame_count_reg + 8'd1;
               end
            end
            default: state <= SEARCH;
         endcase
      end
   end

   assign vid.pix_x       = pix_x_reg;
   assign vid.pix_y       = pix_y_reg;
   assign vid.pix_rgb     = pix_rgb_reg;
   assign vid.pix_valid   = pix_valid_reg;
   assign vid.frame_start = frame_start_reg;
   assign vid.locked      = locked_reg;
   assign vid.frame_count = frame_count_reg;
   assign vid.err_count   = err_count_reg;

endmodule
